// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (tx state enum, line levels, parity helper)
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;
  // Callers zero-extend data to 9 bits; the padding does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte handshake from TX byte source to framer
//   tx_data  : byte to send, sampled on accept
//   tx_valid : source has a byte
//   tx_ready : framer can accept (idle only)
interface uart_tx_frame_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framing stage (start, DATA_W bits LSB first, optional parity, stop)
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   baud_tick  : one-clk pulse per bit period from the upstream counter
//   tx         : byte handshake (slave side)
//   txd        : registered serial line, idle high
//   busy       : high whenever not idle
//   frame_done : one-clk pulse on the final stop tick
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               baud_tick,
  uart_tx_frame_if.slave     tx,
  output logic               txd,
  output logic               busy,
  output logic               frame_done
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_frame: unsupported parameter combination");
  end
  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              stop_q, stop_d, txd_q, txd_d;
  logic              accept, last_bit, last_stop, after_data;
  assign accept    = state_q == ST_IDLE && tx.tx_valid;
  assign last_bit  = cnt_q == LAST_BIT;
  assign last_stop = stop_q == LAST_STOP;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign after_data = par_q;
`else
  assign after_data = LINE_STOP;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = accept ? ST_ARMED : ST_IDLE;
      ST_ARMED:  state_d = baud_tick ? ST_START : ST_ARMED;
      ST_START:  state_d = baud_tick ? ST_DATA : ST_START;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   state_d = (baud_tick && last_bit) ? ST_PARITY : ST_DATA;
      ST_PARITY: state_d = baud_tick ? ST_STOP : ST_PARITY;
`else
      ST_DATA:   state_d = (baud_tick && last_bit) ? ST_STOP : ST_DATA;
`endif
      ST_STOP:   state_d = (baud_tick && last_stop) ? ST_IDLE : ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
  end
  // A tick in the accept cycle falls through untouched because IDLE is not in the tick case.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      shift_d = tx.tx_data;
      cnt_d   = '0;
      stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = parity_bit(9'(tx.tx_data), 1'(PARITY_ODD));
`endif
    end
    if (baud_tick) begin
      case (state_q)
        ST_ARMED: txd_d = LINE_START;
        ST_START: begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
        ST_DATA: begin
          txd_d   = last_bit ? after_data : shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = last_bit ? cnt_q : cnt_q + 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: txd_d = LINE_STOP;
`endif
        ST_STOP: begin
          txd_d  = LINE_STOP;
          stop_d = ~stop_q;
        end
        default: ;
      endcase
    end
    tx.tx_ready = state_q == ST_IDLE;
    busy        = state_q != ST_IDLE;
    frame_done  = state_q == ST_STOP && baud_tick && last_stop;
  end
  assign txd = txd_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed table-driven bench for uart_tx_frame
module tb_uart_tx_frame;
  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          len;
    logic [0:11] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] valid_v = 4'h0;
  wire  [3:0] txd_w, busy_w, done_w, ready_w;
  int         checks = 0, errors = 0;
  int         done_cnt, done_at, tick_idx, ready_cnt;
  logic [0:31] bits;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_W(8)) if0 ();
  uart_tx_frame_if #(.DATA_W(8)) if1 ();
  uart_tx_frame_if #(.DATA_W(8)) if2 ();
  uart_tx_frame_if #(.DATA_W(8)) if3 ();
  assign if0.tx_data = tx_data;
  assign if1.tx_data = tx_data;
  assign if2.tx_data = tx_data;
  assign if3.tx_data = tx_data;
  assign if0.tx_valid = valid_v[0];
  assign if1.tx_valid = valid_v[1];
  assign if2.tx_valid = valid_v[2];
  assign if3.tx_valid = valid_v[3];
  assign ready_w = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

  uart_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx(if0.slave),
    .txd(txd_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
  uart_tx_frame #(.DATA_W(8), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx(if1.slave),
    .txd(txd_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
  uart_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) u2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx(if2.slave),
    .txd(txd_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
  uart_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(1)) u3 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx(if3.slave),
    .txd(txd_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear();
    done_cnt  = 0;
    done_at   = -1;
    tick_idx  = 0;
    ready_cnt = 0;
    bits      = '0;
  endtask

  // One baud period: tick pulse then 15 quiet clocks; starts and ends at a negedge.
  task automatic tick_once(input int sel);
    baud_tick = 1'b1;
    #1;
    if (done_w[sel]) begin
      done_cnt++;
      done_at = tick_idx;
    end
    @(negedge clk);
    baud_tick = 1'b0;
    bits[tick_idx] = txd_w[sel];
    ready_cnt += int'(ready_w[sel]);
    repeat (15) begin
      @(negedge clk);
      ready_cnt += int'(ready_w[sel]);
    end
    tick_idx++;
  endtask

  task automatic accept(input int sel, input logic [7:0] d);
    chk($sformatf("ready_%0d_%h", sel, d), 32'(ready_w[sel]), 32'd1);
    tx_data = d;
    valid_v[sel] = 1'b1;
    @(negedge clk);
    valid_v[sel] = 1'b0;
    tx_data = ~d;
    chk($sformatf("armed_%0d_%h", sel, d), 32'({txd_w[sel], busy_w[sel]}), 32'b11);
    clear();
  endtask

  task automatic send_frame(input vec_t v);
    accept(v.sel, v.data);
    for (int i = 0; i <= v.len; i++) tick_once(v.sel);
    chk($sformatf("bits_%0d_%h", v.sel, v.data), 32'(bits[0:11]), 32'(v.exp));
    chk($sformatf("done_cnt_%0d_%h", v.sel, v.data), done_cnt, 1);
    chk($sformatf("done_at_%0d_%h", v.sel, v.data), done_at, v.len);
    chk($sformatf("idle_%0d_%h", v.sel, v.data),
        32'({ready_w[v.sel], busy_w[v.sel], txd_w[v.sel]}), 32'b101);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    vecs.push_back('{0, 8'hA5, 10, 12'b010100101110});
    vecs.push_back('{0, 8'h00, 10, 12'b000000000110});
    vecs.push_back('{0, 8'hFF, 10, 12'b011111111110});
    vecs.push_back('{0, 8'h3C, 10, 12'b000111100110});
    vecs.push_back('{0, 8'h01, 10, 12'b010000000110});
    vecs.push_back('{0, 8'h80, 10, 12'b000000001110});
    vecs.push_back('{1, 8'h3C, 11, 12'b000111100111});
`ifdef UART_TX_PARITY_EN
    vecs.push_back('{2, 8'h07, 11, 12'b011100000111});
    vecs.push_back('{3, 8'h07, 11, 12'b011100000011});
`endif
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_state_%0d", k),
          32'({txd_w[k], ready_w[k], busy_w[k], done_w[k]}), 32'b1100);
    reset = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) send_frame(vecs[i]);

    chk("b2b_ready_first", 32'(ready_w[0]), 32'd1);
    tx_data = 8'h00;
    valid_v[0] = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    clear();
    for (int i = 0; i < 21; i++) begin
      if (i == 11) valid_v[0] = 1'b0;
      tick_once(0);
    end
    chk("b2b_ready_cycles", ready_cnt, 1);
    tick_once(0);
    chk("b2b_bits", bits, 32'b0000000001_1_0_11111111_1_1_0000000000);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_done_at", done_at, 21);

    accept(0, 8'hA5);
    for (int i = 0; i < 5; i++) tick_once(0);
    chk("pre_reset_txd", 32'(txd_w[0]), 32'd0);
    #3 reset = 1'b0;
    #1 chk("rst_txd_busy", 32'({txd_w[0], busy_w[0]}), 32'b10);
    @(negedge clk);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) tick_once(0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_hold", 32'({txd_w[0], ready_w[0]}), 32'b11);
    reset = 1'b1;
    @(negedge clk);
    v = '{0, 8'hC3, 10, 12'b011000011110};
    send_frame(v);

    tx_data = 8'h5A;
    valid_v[0] = 1'b1;
    baud_tick = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    baud_tick = 1'b0;
    tx_data = 8'h00;
    clear();
    chk("coinc_armed", 32'({txd_w[0], busy_w[0]}), 32'b11);
    repeat (15) @(negedge clk);
    chk("coinc_hold", 32'(txd_w[0]), 32'd1);
    tick_once(0);
    chk("coinc_start_full", 32'(txd_w[0]), 32'd0);
    for (int i = 0; i < 10; i++) tick_once(0);
    chk("coinc_bits", 32'(bits[0:11]), 32'(12'b001011010110));
    chk("coinc_done_at", done_at, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framing stage.
- Consumes the one-cycle baud enable pulse from the upstream baud/bit-tick counter.
- Serialises a parallel byte onto txd as start bit, DATA_W data bits LSB first, optional parity bit, then STOP_BITS stop bits.
- Sits between the TX byte source (valid/ready handshake) and the pad driver.

Parameters:
- DATA_W, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-clk pulse once per bit period, from the upstream counter.
- tx_data  input  DATA_W  byte to send; sampled on accept.
- tx_valid  input  1  source has a byte.
- tx_ready  output  1  block can accept a byte (high only in IDLE).
- txd  output  1  serial line, registered, idle high.
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-clk pulse when the last stop bit completes.

Behaviour:
- Reset is asynchronous and active-low:
  - state=IDLE, txd=1, tx_ready=1, busy=0, frame_done=0, shift register=0, bit count=0.
  - Reset asserted mid-frame forces txd=1 immediately and abandons the frame; no frame_done is produced.
- States: IDLE, ARMED, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, txd=1.
  - Accept occurs when tx_valid & tx_ready at a clk edge: latch tx_data into the shift register, clear bit count, go to ARMED.
  - A baud_tick in the accept cycle is ignored.
- ARMED: txd stays 1. On the next baud_tick, txd<=0 and the state goes to START. This aligns every bit to exactly one baud period.
- START: on baud_tick, txd<=shift[0], shift right, go to DATA.
- DATA:
  - On each baud_tick, increment the bit count.
  - While count < DATA_W-1, drive the next LSB.
  - At count == DATA_W-1: go to PARITY with txd<=parity if the parity feature is built; otherwise go to STOP with txd<=1.
- PARITY: on baud_tick, txd<=1, go to STOP.
- STOP:
  - Counts STOP_BITS ticks with txd=1.
  - On the final tick: state<=IDLE, frame_done=1 for that one cycle, tx_ready rises the next cycle.
- Back-to-back frames:
  - A byte accepted the cycle tx_ready rises enters ARMED.
  - The next baud_tick starts its start bit, so there is no extra idle bit.
- Control inputs:
  - tx_valid and tx_data are ignored outside IDLE.
  - tx_data may change after accept without effect.
- Without the parity feature, frame length = 1 + DATA_W + STOP_BITS baud periods. With DATA_W=8 and STOP_BITS=1 this is a 10-tick frame.
- The bit counter is $clog2(DATA_W) bits wide and resets to 0 at each frame start. It never wraps inside a frame.
- baud_tick held high continuously advances one bit per clk. This is legal and is used for fast simulation.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Parity bit is the XOR of the latched data, inverted when PARITY_ODD=1.
  - It is computed at accept and transmitted in state PARITY.
  - Frame gains one baud period.
- Undefined: the PARITY state and parity logic are absent; DATA goes directly to STOP; PARITY_ODD is unused.

Decomposition:
- Shared package uart_pkg holds:
  - the tx state enum;
  - constants for line idle level (1), start level (0) and stop level (1);
  - a parity function shared with the future uart_rx_frame.
- No sub-module. Tick generation stays in the existing upstream counter, and this block only consumes baud_tick.

Test Plan:
- Reset, then tx_data=8'hA5 with tx_valid pulse and baud_tick every 16 clk:
  - txd sequence per tick is 0,1,0,1,0,0,1,0,1,1.
  - frame_done pulses once, at 10 ticks after the start bit.
- Hold tx_valid high with 8'h00 then 8'hFF, back-to-back:
  - second start bit begins on the tick right after the first frame's stop bit;
  - tx_ready is high for exactly one cycle between frames.
- Assert reset low during data bit 3:
  - txd=1 and busy=0 in the same cycle;
  - no frame_done;
  - a new byte after release sends cleanly.
- baud_tick coincident with the accept cycle: txd stays 1 until the following tick, and the start bit lasts a full tick period.
- STOP_BITS=2, 8'h3C: txd is high for 2 tick periods after the data bits, and frame_done comes at tick 11.
- UART_TX_PARITY_EN defined, PARITY_ODD=0, tx_data=8'h07: parity bit = 1, and frame_done comes at tick 11.
- Same configuration with PARITY_ODD=1: parity bit = 0.
